// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, flag bit positions and the response slot layout.
package alu_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00,
        OP_SUB  = 6'h01,
        OP_AND  = 6'h02,
        OP_OR   = 6'h03,
        OP_XOR  = 6'h04,
        OP_SLL  = 6'h05,
        OP_SRL  = 6'h06,
        OP_SRA  = 6'h07,
        OP_SCMP = 6'h08,
        OP_UCMP = 6'h09
    } alu_op_e;

    // Bit positions inside the 2-bit {LT,EQ} flag vector.
    localparam int EQ = 0;
    localparam int LT = 1;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  flags;
    } rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. The immediate form replaces op2 with its
// sign-extended low 12 bits. Flags compare op1 against the effective op2;
// LT is unsigned for UCMP and signed otherwise.
module alu
    import alu_pkg::*;
(
    input  alu_op_e     opc,
    input  logic        imm,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic [1:0]  flags_res
);

    logic [31:0] op2_eff;
    logic        lt;

    // Operand selection, comparison flags and result mux.
    always_comb begin
        op2_eff = imm ? {{20{op2[11]}}, op2[11:0]} : op2;
        lt      = (opc == OP_UCMP) ? (op1 < op2_eff)
                                   : ($signed(op1) < $signed(op2_eff));
        flags_res     = '0;
        flags_res[EQ] = (op1 == op2_eff);
        flags_res[LT] = lt;
        res = '0;
        case (opc)
            OP_ADD:  res = op1 + op2_eff;
            OP_SUB:  res = op1 - op2_eff;
            OP_AND:  res = op1 & op2_eff;
            OP_OR:   res = op1 | op2_eff;
            OP_XOR:  res = op1 ^ op2_eff;
            OP_SLL:  res = op1 << op2_eff[4:0];
            OP_SRL:  res = op1 >> op2_eff[4:0];
            OP_SRA:  res = $unsigned($signed(op1) >>> op2_eff[4:0]);
            OP_SCMP: res = {31'b0, lt};
            OP_UCMP: res = {31'b0, lt};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin arbitration and a
// one-entry response slot per requester (result visible one cycle after grant).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ-1:0][5:0]       req_opc_i,
    input  logic [NREQ-1:0]            req_imm_i,
    input  logic [NREQ-1:0][31:0]      req_op1_i,
    input  logic [NREQ-1:0][31:0]      req_op2_i,
    output logic [NREQ-1:0]            rsp_valid_o,
    input  logic [NREQ-1:0]            rsp_ready_i,
    output logic [NREQ-1:0][31:0]      rsp_res_o,
    output logic [NREQ-1:0][1:0]       rsp_flags_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]  last_grant_q;
    logic [NREQ-1:0]   rsp_valid_q;
    rsp_t [NREQ-1:0]   slot_q;

    logic [NREQ-1:0]   eligible;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand;

    logic [31:0]       alu_res;
    logic [1:0]        alu_flags;

    // A requester may issue when its slot is free or is being drained this cycle.
    always_comb begin
        eligible = req_valid_i & (~rsp_valid_q | rsp_ready_i);
    end

    // Round-robin pick starting just after the last grant; no grant during reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_grant_q;
        cand    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((32'(last_grant_q) + i) % NREQ);
            if (!gnt_any && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst_i) begin
            gnt_any = 1'b0;
        end
        req_ready_o = '0;
        if (gnt_any) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    alu u_alu (
        .opc       (alu_op_e'(req_opc_i[gnt_idx])),
        .imm       (req_imm_i[gnt_idx]),
        .op1       (req_op1_i[gnt_idx]),
        .op2       (req_op2_i[gnt_idx]),
        .res       (alu_res),
        .flags_res (alu_flags)
    );

    // Response slots: refill on grant (wins over drain), clear on drain, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q  <= '0;
            slot_q       <= '0;
            last_grant_q <= IDX_W'(NREQ - 1);
        end else begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                if (req_ready_o[r]) begin
                    rsp_valid_q[r]  <= 1'b1;
                    slot_q[r].res   <= alu_res;
                    slot_q[r].flags <= alu_flags;
                end else if (rsp_ready_i[r]) begin
                    rsp_valid_q[r] <= 1'b0;
                end
            end
            if (gnt_any) begin
                last_grant_q <= gnt_idx;
            end
        end
    end

    // Unpack the slots onto the response ports.
    always_comb begin
        rsp_valid_o = rsp_valid_q;
        rsp_res_o   = '0;
        rsp_flags_o = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            rsp_res_o[r]   = slot_q[r].res;
            rsp_flags_o[r] = slot_q[r].flags;
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requester ports, legal range 2..8.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 req_valid_i  input  NREQ  per-requester operation valid.
REQ-005 req_ready_o  output  NREQ  per-requester operation accepted this cycle.
REQ-006 req_opc_i  input  NREQx6  ALU opcode (alu_op_e encoding) per requester.
REQ-007 req_imm_i  input  NREQ  immediate-form flag per requester.
REQ-008 req_op1_i, req_op2_i  input  NREQx32 each  operands per requester.
REQ-009 rsp_valid_o  output  NREQ  per-requester result valid.
REQ-010 rsp_ready_i  input  NREQ  per-requester result consumed.
REQ-011 rsp_res_o  output  NREQx32  result per requester.
REQ-012 rsp_flags_o  output  NREQx2  {LT,EQ} flags per requester, indexed by the package EQ/LT constants.

Function
REQ-013 The block SHALL instantiate exactly one alu and share it among NREQ requesters, at most one operation per cycle.
REQ-014 A requester r SHALL be eligible when req_valid_i[r]=1 and its response slot is empty or is being drained this cycle (rsp_valid_o[r]&rsp_ready_i[r]).
REQ-015 Grant SHALL be round-robin: search starts at last_grant+1, wrapping modulo NREQ; the first eligible requester wins.
REQ-016 req_ready_o SHALL be one-hot or zero, asserted only for the granted requester, and combinationally derived from same-cycle inputs and state.
REQ-017 The granted requester's opc/imm/op1/op2 SHALL drive the alu; res and flags_res SHALL be captured into that requester's response slot at the same edge; rsp_valid_o[r] rises the next cycle (latency 1).
REQ-018 last_grant SHALL update only on a cycle with a grant; idle cycles leave it unchanged.
REQ-019 A response slot SHALL hold rsp_res_o/rsp_flags_o stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-020 Drain and refill of the same slot in one cycle SHALL be permitted, giving 1 op/cycle sustained throughput to a single requester with rsp_ready_i held high.
REQ-021 A slot drained with no refill SHALL clear rsp_valid_o the next cycle.
REQ-022 Non-granted requesters SHALL see req_ready_o=0 and their inputs SHALL be ignored; requester inputs need not be held stable beyond the accepting cycle.
REQ-023 No requester SHALL wait more than NREQ-1 grants to others while continuously eligible.

Reset
REQ-024 While rst_i=1 at an edge: all rsp_valid_o cleared, last_grant set to NREQ-1 so requester 0 has first priority; rsp_res_o and rsp_flags_o reset to 0.
REQ-025 During the reset cycle req_ready_o SHALL be 0; an operation presented then is not accepted, and in-flight results are discarded.

Structure
REQ-026 alu_op_e, EQ/LT flag indices, and a response struct {res[31:0], flags[1:0]} SHALL live in alu_pkg.
REQ-027 The sole sub-module SHALL be the existing alu; arbitration and response slots are implemented inline.

Verification
REQ-028 Single requester 0 issues ADD 5+7 with rsp_ready high -> rsp_valid_o[0]=1 one cycle later, rsp_res_o[0]=12.
REQ-029 Both requesters valid every cycle after reset, rsp_ready high -> grants alternate 0,1,0,1; requester 1 issues SUB 1-2 -> 0xFFFFFFFF.
REQ-030 Requester 0 SCMP 0x80000000 vs 0x7FFFFFFF with rsp_ready_i[0]=0 for 3 cycles -> flags LT=1 EQ=0 held stable, req_ready_o[0]=0 for a second request until drained, requester 1 meanwhile granted every cycle.
REQ-031 Requester 0 streams 4 back-to-back ORs with rsp_ready high, requester 1 idle -> 4 results on 4 consecutive cycles, no bubbles.
REQ-032 Assert rst_i while rsp_valid_o[1]=1 -> next cycle all rsp_valid_o=0; first post-reset simultaneous request grants requester 0.
REQ-033 Randomized 10000-cycle run with random valid/ready vs. alu reference model -> every result matches, order per requester preserved, no requester waits more than NREQ-1 grants.
